pipe_ctrl_hazard: RTL and testbench

//  Consumer side of the decoder's control bundle. Carries the decoded control word and register indices through EX, MEM and WB.

---
 rtl/pipe_ctrl_hazard.sv | 151 +++++++++++++++
 tb/tb_pipe_ctrl_hazard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - EX/MEM/WB control pipeline with load-use stall, ID kill and forwarding selects
module pipe_ctrl_hazard #(
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_AW-1:0] wb_rd
);

  localparam int BIT_REG_WRITE = 0;
  localparam int BIT_MEM_READ  = 2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;

  logic              mem_valid_q;
  logic [CTRL_W-1:0] mem_ctrl_q;
  logic [REG_AW-1:0] mem_rd_q;

  logic              wb_valid_q;
  logic [CTRL_W-1:0] wb_ctrl_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic              rs1_hit;
  logic              rs2_hit;
  logic              stall_w;
  logic [CTRL_W-1:0] id_ctrl_cap;

  // A load in EX whose result ID needs cannot be forwarded in time; hold ID one cycle.
  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == ex_rd_q);
    rs2_hit = id_use_rs2 && (id_rs2 == ex_rd_q);
    stall_w = id_valid && ex_valid_q && ex_ctrl_q[BIT_MEM_READ] &&
              (ex_rd_q != '0) && (rs1_hit || rs2_hit) && !flush;
  end

  always_comb begin
    id_ctrl_cap = id_ctrl;
    if (id_rd == '0) begin
      id_ctrl_cap[BIT_REG_WRITE] = 1'b0;
    end
    if (!id_valid) begin
      id_ctrl_cap = '0;
    end
  end

  always_comb begin
    ex_valid_d = id_valid;
    ex_ctrl_d  = id_ctrl_cap;
    ex_rd_d    = id_rd;
    ex_rs1_d   = id_rs1;
    ex_rs2_d   = id_rs2;
    if (flush || stall_w) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rd_d    = '0;
      ex_rs1_d   = '0;
      ex_rs2_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_rd_q     <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      mem_valid_q <= ex_valid_q;
      mem_ctrl_q  <= ex_ctrl_q;
      mem_rd_q    <= ex_rd_q;
      wb_valid_q  <= mem_valid_q;
      wb_ctrl_q   <= mem_ctrl_q;
      wb_rd_q     <= mem_rd_q;
    end
  end

  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // MEM is the younger producer, so it always beats WB for the same register.
  always_comb begin
    mem_fwd_ok = mem_valid_q && mem_ctrl_q[BIT_REG_WRITE] && (mem_rd_q != '0);
    wb_fwd_ok  = wb_valid_q && wb_ctrl_q[BIT_REG_WRITE] && (wb_rd_q != '0);

    fwd_a = FWD_RF;
    if (mem_fwd_ok && (mem_rd_q == ex_rs1_q)) begin
      fwd_a = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q)) begin
      fwd_a = FWD_WB;
    end

    fwd_b = FWD_RF;
    if (mem_fwd_ok && (mem_rd_q == ex_rs2_q)) begin
      fwd_b = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q)) begin
      fwd_b = FWD_WB;
    end
  end

  assign stall     = stall_w;
  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign ex_rd     = ex_rd_q;
  assign mem_valid = mem_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_rd    = mem_rd_q;
  assign wb_valid  = wb_valid_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// tb/tb_pipe_ctrl_hazard.sv - directed scoreboard bench for pipe_ctrl_hazard
module tb_pipe_ctrl_hazard;

  localparam logic [7:0] LW     = 8'h27;
  localparam logic [7:0] ADD    = 8'h81;
  localparam logic [7:0] ADD_X0 = 8'h80;
  localparam logic [7:0] SW     = 8'h28;
  localparam logic [7:0] BEQ    = 8'h50;
  localparam logic [7:0] JAL    = 8'h11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [7:0] id_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       flush;
  logic       stall;
  logic       ex_valid, mem_valid, wb_valid;
  logic [7:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic [1:0] fwd_a, fwd_b;

  pipe_ctrl_hazard #(.REG_AW(5), .CTRL_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       stall;
    logic [1:0] fa, fb;
    logic       exv;
    logic [7:0] exc;
    logic [4:0] exrd;
    logic       mv;
    logic [7:0] mc;
    logic [4:0] mrd;
    logic       wv;
    logic [7:0] wc;
    logic [4:0] wrd;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  task automatic cmp(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0h expected %0h", n, name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp("stall",     e.n, stall,     e.stall);
        cmp("fwd_a",     e.n, fwd_a,     e.fa);
        cmp("fwd_b",     e.n, fwd_b,     e.fb);
        cmp("ex_valid",  e.n, ex_valid,  e.exv);
        cmp("ex_ctrl",   e.n, ex_ctrl,   e.exc);
        cmp("ex_rd",     e.n, ex_rd,     e.exrd);
        cmp("mem_valid", e.n, mem_valid, e.mv);
        cmp("mem_ctrl",  e.n, mem_ctrl,  e.mc);
        cmp("mem_rd",    e.n, mem_rd,    e.mrd);
        cmp("wb_valid",  e.n, wb_valid,  e.wv);
        cmp("wb_ctrl",   e.n, wb_ctrl,   e.wc);
        cmp("wb_rd",     e.n, wb_rd,     e.wrd);
      end
    end
  end

  task automatic id(input logic v, input logic [7:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic u1, input logic u2);
    id_valid   = v;
    id_ctrl    = c;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_rd      = rd;
    id_use_rs1 = u1;
    id_use_rs2 = u2;
  endtask

  task automatic idle();
    id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Push the expectation for the current cycle, then advance one edge.
  task automatic chk(input logic st, input logic [1:0] fa, input logic [1:0] fb,
                     input logic exv, input logic [7:0] exc, input logic [4:0] exrd,
                     input logic mv, input logic [7:0] mc, input logic [4:0] mrd,
                     input logic wv, input logic [7:0] wc, input logic [4:0] wrd);
    exp_t e;
    e.n = step_no; e.stall = st; e.fa = fa; e.fb = fb;
    e.exv = exv; e.exc = exc; e.exrd = exrd;
    e.mv = mv; e.mc = mc; e.mrd = mrd;
    e.wv = wv; e.wc = wc; e.wrd = wrd;
    q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    rst_n = 1'b1;

    // load-use stall, bubble, then WB forward
    id(1, LW, 1, 0, 5, 1, 0);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    id(1, ADD, 5, 2, 6, 1, 1);
    chk(1, 2'b00, 2'b00, 1, LW, 5, 0, 8'h00, 0, 0, 8'h00, 0);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 1, LW, 5, 0, 8'h00, 0);
    idle();
    chk(0, 2'b01, 2'b00, 1, ADD, 6, 0, 8'h00, 0, 1, LW, 5);

    // MEM priority over WB
    id(1, ADD, 1, 2, 3, 1, 1);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 1, ADD, 6, 0, 8'h00, 0);
    id(1, ADD, 4, 0, 3, 1, 0);
    chk(0, 2'b00, 2'b00, 1, ADD, 3, 0, 8'h00, 0, 1, ADD, 6);
    id(1, ADD, 3, 3, 7, 1, 1);
    chk(0, 2'b00, 2'b00, 1, ADD, 3, 1, ADD, 3, 0, 8'h00, 0);
    idle();
    chk(0, 2'b10, 2'b10, 1, ADD, 7, 1, ADD, 3, 1, ADD, 3);

    // MEM at rd=4, WB at rd=3
    id(1, ADD, 0, 0, 3, 0, 0);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 1, ADD, 7, 1, ADD, 3);
    id(1, ADD, 0, 0, 4, 0, 0);
    chk(0, 2'b00, 2'b00, 1, ADD, 3, 0, 8'h00, 0, 1, ADD, 7);
    id(1, ADD, 3, 4, 8, 1, 1);
    chk(0, 2'b00, 2'b00, 1, ADD, 4, 1, ADD, 3, 0, 8'h00, 0);
    idle();
    chk(0, 2'b01, 2'b10, 1, ADD, 8, 1, ADD, 4, 1, ADD, 3);

    // flush kills sw in ID, branch moves on to MEM
    id(1, BEQ, 1, 2, 0, 1, 1);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 1, ADD, 8, 1, ADD, 4);
    id(1, SW, 2, 9, 0, 1, 1);
    flush = 1'b1;
    chk(0, 2'b00, 2'b00, 1, BEQ, 0, 0, 8'h00, 0, 1, ADD, 8);
    idle();
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 1, BEQ, 0, 0, 8'h00, 0);

    // flush beats a simultaneous load-use stall
    id(1, LW, 1, 0, 10, 1, 0);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 8'h00, 0, 1, BEQ, 0);
    id(1, ADD, 10, 0, 11, 1, 0);
    flush = 1'b1;
    chk(0, 2'b00, 2'b00, 1, LW, 10, 0, 8'h00, 0, 0, 8'h00, 0);
    idle();
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 1, LW, 10, 0, 8'h00, 0);

    // JAL keeps reg_write through a flush
    id(1, JAL, 0, 0, 1, 0, 0);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 8'h00, 0, 1, LW, 10);
    id(1, ADD, 1, 0, 12, 1, 0);
    flush = 1'b1;
    chk(0, 2'b00, 2'b00, 1, JAL, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    idle();
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 1, JAL, 1, 0, 8'h00, 0);

    // write to x0 is dropped and never forwarded
    id(1, ADD, 1, 0, 0, 1, 0);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 8'h00, 0, 1, JAL, 1);
    id(1, ADD, 0, 0, 13, 1, 1);
    chk(0, 2'b00, 2'b00, 1, ADD_X0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    idle();
    chk(0, 2'b00, 2'b00, 1, ADD, 13, 1, ADD_X0, 0, 0, 8'h00, 0);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 1, ADD, 13, 1, ADD_X0, 0);

    // reset with every stage full
    id(1, ADD, 1, 0, 14, 1, 0);
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 8'h00, 0, 1, ADD, 13);
    id(1, ADD, 1, 0, 15, 1, 0);
    chk(0, 2'b00, 2'b00, 1, ADD, 14, 0, 8'h00, 0, 0, 8'h00, 0);
    id(1, LW, 1, 0, 16, 1, 0);
    chk(0, 2'b00, 2'b00, 1, ADD, 15, 1, ADD, 14, 0, 8'h00, 0);
    id(1, ADD, 16, 0, 17, 1, 0);
    rst_n = 1'b0;
    chk(1, 2'b00, 2'b00, 1, LW, 16, 1, ADD, 15, 1, ADD, 14);
    rst_n = 1'b1;
    chk(0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    idle();
    chk(0, 2'b00, 2'b00, 1, ADD, 17, 0, 8'h00, 0, 0, 8'h00, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
